// File: rtl/mips_pc_pkg.sv
// Shared definitions for the multicycle MIPS program-counter stage.
// Contents: 32-bit word type, pc_source and branch_op encodings, default reset PC and
// exception vector, and the branch-offset extension helper.
package mips_pc_pkg;

  typedef logic [31:0] word_t;

  // Next-PC source select; 3'b110 and 3'b111 are reserved (PC holds).
  localparam logic [2:0] PCSRC_INC    = 3'b000;
  localparam logic [2:0] PCSRC_BRANCH = 3'b001;
  localparam logic [2:0] PCSRC_JUMP   = 3'b010;
  localparam logic [2:0] PCSRC_RS     = 3'b011;
  localparam logic [2:0] PCSRC_EXC    = 3'b100;
  localparam logic [2:0] PCSRC_EPC    = 3'b101;

  // Branch condition select.
  localparam logic [1:0] BOP_BEQ = 2'b00;
  localparam logic [1:0] BOP_BNE = 2'b01;
  localparam logic [1:0] BOP_BLT = 2'b10;
  localparam logic [1:0] BOP_BGT = 2'b11;

  localparam word_t RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam word_t EXC_VECTOR_DEFAULT = 32'h0000_0080;

  // Word offset -> byte offset: sign-extend and shift left by two.
  function automatic word_t branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation.
// Ports:
//   branch_op_i  branch kind (beq, bne, blt, bgt)
//   alu_zero_i   ALU zero flag
//   alu_lt_i     ALU signed less-than flag
//   cond_o       branch condition is true
module branch_cond_eval
  import mips_pc_pkg::*;
(
  input  logic [1:0] branch_op_i,
  input  logic       alu_zero_i,
  input  logic       alu_lt_i,
  output logic       cond_o
);

  always_comb begin
    cond_o = 1'b0;
    unique case (branch_op_i)
      BOP_BEQ: cond_o = alu_zero_i;
      BOP_BNE: cond_o = ~alu_zero_i;
      BOP_BLT: cond_o = alu_lt_i;
      BOP_BGT: cond_o = ~alu_lt_i & ~alu_zero_i;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_source_unit.sv
// Program-counter stage of the multicycle MIPS datapath.
// Holds PC and EPC, latches the branch target during decode, and selects the next PC from
// one of six sources when the control unit strobes an update.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   ir_imm16         IR[15:0] branch offset in words
//   ir_target26      IR[25:0] jump index
//   rs_value         register A value (jr target)
//   alu_zero/alu_lt  ALU flags for the branch condition
//   pc_write         unconditional PC update strobe
//   pc_write_cond    PC update strobe qualified by the branch condition
//   branch_op        branch kind
//   pc_source        next-PC source select
//   target_capture   latch PC + 4 + offset into branch_target
//   epc_write        EPC <= PC - 4
//   pc, epc, branch_target, target_valid, pc_updated   registered state/status outputs
module pc_source_unit
  import mips_pc_pkg::*;
#(
  parameter word_t RESET_PC   = RESET_PC_DEFAULT,
  parameter word_t EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir_imm16,
  input  logic [25:0] ir_target26,
  input  logic [31:0] rs_value,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic [2:0]  pc_source,
  input  logic        target_capture,
  input  logic        epc_write,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic [31:0] branch_target,
  output logic        target_valid,
  output logic        pc_updated
);

  word_t pc_q, pc_d;
  word_t epc_q, epc_d;
  word_t bt_q, bt_d;
  logic  tv_q, tv_d;
  logic  upd_q, upd_d;

  logic  cond;
  logic  do_write;
  logic  src_ok;
  logic  pc_move;
  word_t pc_next;

  branch_cond_eval u_branch_cond_eval (
    .branch_op_i (branch_op),
    .alu_zero_i  (alu_zero),
    .alu_lt_i    (alu_lt),
    .cond_o      (cond)
  );

  assign do_write = pc_write | (pc_write_cond & cond);

  always_comb begin
    pc_next = pc_q;
    src_ok  = 1'b1;
    case (pc_source)
      PCSRC_INC:    pc_next = pc_q + 32'd4;
      PCSRC_BRANCH: pc_next = bt_q;  // used even when stale; no stall here
      PCSRC_JUMP:   pc_next = {pc_q[31:28], ir_target26, 2'b00};
      PCSRC_RS:     pc_next = rs_value;
      PCSRC_EXC:    pc_next = EXC_VECTOR;
      PCSRC_EPC:    pc_next = epc_q;  // pre-edge EPC, even with a concurrent epc_write
      default: begin
        pc_next = pc_q;
        src_ok  = 1'b0;
      end
    endcase
  end

  // A reserved source turns the write into a no-op: no pulse, target_valid untouched.
  assign pc_move = do_write & src_ok;

  always_comb begin
    pc_d  = pc_move ? pc_next : pc_q;
    epc_d = epc_write ? (pc_q - 32'd4) : epc_q;
    bt_d  = target_capture ? (pc_q + 32'd4 + branch_offset(ir_imm16)) : bt_q;
    // A capture in the same cycle as an update wins: the new target is unconsumed.
    tv_d  = target_capture | (tv_q & ~pc_move);
    upd_d = pc_move;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
      bt_q  <= '0;
      tv_q  <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      bt_q  <= bt_d;
      tv_q  <= tv_d;
      upd_q <= upd_d;
    end
  end

  assign pc            = pc_q;
  assign epc           = epc_q;
  assign branch_target = bt_q;
  assign target_valid  = tv_q;
  assign pc_updated    = upd_q;

endmodule

// File: tb/tb_pc_source_unit.sv
// Scoreboard bench for pc_source_unit: the driver pushes the expected post-edge state of a
// behavioural model for every cycle it drives; a monitor pops and compares after each edge.
module tb_pc_source_unit;

  localparam logic [31:0] RstPc  = 32'h0000_0000;
  localparam logic [31:0] ExcVec = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ir_imm16 = '0;
  logic [25:0] ir_target26 = '0;
  logic [31:0] rs_value = '0;
  logic        alu_zero = 1'b0;
  logic        alu_lt = 1'b0;
  logic        pc_write = 1'b0;
  logic        pc_write_cond = 1'b0;
  logic [1:0]  branch_op = '0;
  logic [2:0]  pc_source = '0;
  logic        target_capture = 1'b0;
  logic        epc_write = 1'b0;
  logic [31:0] pc, epc, branch_target;
  logic        target_valid, pc_updated;

  always #5 clk = ~clk;

  pc_source_unit dut (
    .clk            (clk),
    .reset          (reset),
    .ir_imm16       (ir_imm16),
    .ir_target26    (ir_target26),
    .rs_value       (rs_value),
    .alu_zero       (alu_zero),
    .alu_lt         (alu_lt),
    .pc_write       (pc_write),
    .pc_write_cond  (pc_write_cond),
    .branch_op      (branch_op),
    .pc_source      (pc_source),
    .target_capture (target_capture),
    .epc_write      (epc_write),
    .pc             (pc),
    .epc            (epc),
    .branch_target  (branch_target),
    .target_valid   (target_valid),
    .pc_updated     (pc_updated)
  );

  typedef struct packed {
    logic        rst;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] rs;
    logic        z;
    logic        lt;
    logic        pw;
    logic        pwc;
    logic [1:0]  bop;
    logic [2:0]  src;
    logic        cap;
    logic        ew;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] bt;
    logic        tv;
    logic        upd;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference state: what the architecture says the registers hold.
  logic [31:0] m_pc = RstPc, m_epc = '0, m_bt = '0;
  logic        m_tv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Drive one cycle of stimulus and predict the state after the coming edge.
  task automatic step(input stim_t s);
    logic        taken, moved;
    logic [31:0] dest;
    logic signed [31:0] words;
    exp_t e;
    @(negedge clk);
    reset          = s.rst;
    ir_imm16       = s.imm;
    ir_target26    = s.tgt;
    rs_value       = s.rs;
    alu_zero       = s.z;
    alu_lt         = s.lt;
    pc_write       = s.pw;
    pc_write_cond  = s.pwc;
    branch_op      = s.bop;
    pc_source      = s.src;
    target_capture = s.cap;
    epc_write      = s.ew;
    if (s.rst) begin
      m_pc = RstPc; m_epc = '0; m_bt = '0; m_tv = 1'b0; moved = 1'b0;
    end else begin
      case (s.bop)
        2'd0:    taken = s.z;                  // beq: equal
        2'd1:    taken = !s.z;                 // bne: not equal
        2'd2:    taken = s.lt;                 // blt: a < b
        default: taken = !(s.lt || s.z);       // bgt: neither less nor equal
      endcase
      dest = m_pc;
      moved = 1'b0;
      if (s.pw || (s.pwc && taken)) begin
        moved = 1'b1;
        case (s.src)
          3'd0:    dest = m_pc + 4;
          3'd1:    dest = m_bt;
          3'd2:    dest = (m_pc & 32'hF000_0000) | (32'(s.tgt) * 4);
          3'd3:    dest = s.rs;
          3'd4:    dest = ExcVec;
          3'd5:    dest = m_epc;
          default: moved = 1'b0;
        endcase
      end
      if (s.cap) begin
        words = 32'($signed(s.imm));
        m_bt  = m_pc + 4 + 32'(words * 4);
      end
      if (s.ew) m_epc = m_pc - 4;
      m_tv = s.cap ? 1'b1 : (moved ? 1'b0 : m_tv);
      m_pc = dest;
    end
    e.pc = m_pc; e.epc = m_epc; e.bt = m_bt; e.tv = m_tv; e.upd = moved;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge that consumed driven stimulus has one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pc", pc, e.pc);
        check("epc", epc, e.epc);
        check("branch_target", branch_target, e.bt);
        check("target_valid", {31'd0, target_valid}, {31'd0, e.tv});
        check("pc_updated", {31'd0, pc_updated}, {31'd0, e.upd});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    waited;

    // Reset state.
    s = idle(); s.rst = 1'b1;
    step(s); step(s);
    settle();
    check("reset pc", pc, RstPc);
    check("reset target_valid", {31'd0, target_valid}, 32'd0);
    check("reset pc_updated", {31'd0, pc_updated}, 32'd0);

    // Sequential increments.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.pw = 1'b1; s.src = 3'b000;
      step(s);
    end
    settle();
    check("inc pc", pc, 32'h0000_000C);
    check("inc pulse", {31'd0, pc_updated}, 32'd1);
    step(idle());
    settle();
    check("pulse drops", {31'd0, pc_updated}, 32'd0);

    // Branch with imm = -1 word: target equals the pre-increment pc.
    s = idle(); s.pw = 1'b1; s.src = 3'b011; s.rs = 32'h0000_0100; step(s);
    s = idle(); s.cap = 1'b1; s.imm = 16'hFFFF; step(s);
    settle();
    check("capture target", branch_target, 32'h0000_0100);
    check("capture valid", {31'd0, target_valid}, 32'd1);
    s = idle(); s.pwc = 1'b1; s.bop = 2'b00; s.z = 1'b1; s.src = 3'b001; step(s);
    settle();
    check("beq taken pc", pc, 32'h0000_0100);
    check("beq consumes valid", {31'd0, target_valid}, 32'd0);
    s = idle(); s.cap = 1'b1; s.imm = 16'hFFFF; step(s);
    s = idle(); s.pwc = 1'b1; s.bop = 2'b00; s.z = 1'b0; s.src = 3'b001; step(s);
    settle();
    check("beq not taken pulse", {31'd0, pc_updated}, 32'd0);

    // Most negative offset wraps through the top of the address space.
    s = idle(); s.cap = 1'b1; s.imm = 16'h8000; step(s);
    settle();
    check("min offset target", branch_target, 32'hFFFE_0104);

    // Jump keeps the upper nibble of the current pc.
    s = idle(); s.pw = 1'b1; s.src = 3'b011; s.rs = 32'hA000_0004; step(s);
    s = idle(); s.pw = 1'b1; s.src = 3'b010; s.tgt = 26'h000_0040; step(s);
    settle();
    check("jump pc", pc, 32'hA000_0100);

    // Exception entry and return.
    s = idle(); s.pw = 1'b1; s.src = 3'b011; s.rs = 32'h0000_0204; step(s);
    s = idle(); s.pw = 1'b1; s.src = 3'b100; s.ew = 1'b1; step(s);
    settle();
    check("exc epc", epc, 32'h0000_0200);
    check("exc pc", pc, ExcVec);
    s = idle(); s.pw = 1'b1; s.src = 3'b101; step(s);
    settle();
    check("rte pc", pc, 32'h0000_0200);

    // bgt cases.
    s = idle(); s.pwc = 1'b1; s.bop = 2'b11; s.src = 3'b000; step(s);
    settle();
    check("bgt taken pc", pc, 32'h0000_0204);
    s.z = 1'b1; step(s);
    settle();
    check("bgt equal not taken", {31'd0, pc_updated}, 32'd0);
    s.pw = 1'b1; step(s);
    settle();
    check("pc_write overrides cond", pc, 32'h0000_0208);

    // Reset wins over a concurrent write; reserved source holds.
    s = idle(); s.cap = 1'b1; step(s);
    s = idle(); s.rst = 1'b1; s.pw = 1'b1; s.src = 3'b000; step(s);
    settle();
    check("mid reset pc", pc, RstPc);
    check("mid reset valid", {31'd0, target_valid}, 32'd0);
    check("mid reset pulse", {31'd0, pc_updated}, 32'd0);
    s = idle(); s.pw = 1'b1; s.src = 3'b011; s.rs = 32'h0000_0040; step(s);
    s = idle(); s.pw = 1'b1; s.src = 3'b110; step(s);
    settle();
    check("reserved holds pc", pc, 32'h0000_0040);
    check("reserved no pulse", {31'd0, pc_updated}, 32'd0);

    // epc wrap from pc = 0.
    s = idle(); s.pw = 1'b1; s.src = 3'b011; s.rs = 32'h0; step(s);
    s = idle(); s.ew = 1'b1; step(s);
    settle();
    check("epc wrap", epc, 32'hFFFF_FFFC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 39) == 0);
      s.imm = 16'($urandom);
      s.tgt = 26'($urandom);
      s.rs  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      s.z   = 1'($urandom);
      s.lt  = 1'($urandom);
      s.pw  = ($urandom_range(0, 3) == 0);
      s.pwc = ($urandom_range(0, 2) == 0);
      s.bop = 2'($urandom);
      s.src = 3'($urandom_range(0, 7));
      s.cap = ($urandom_range(0, 3) == 0);
      s.ew  = ($urandom_range(0, 7) == 0);
      step(s);
    end
    step(idle());

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #3;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
